// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: pipeline-side request/result bundle for muldiv_sequencer
interface muldiv_sequencer_if;
  logic        start;
  logic [5:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, rs_val, rt_val, input busy, done, dz, rd_data, hi, lo);
  modport slave  (input start, op, rs_val, rt_val, output busy, done, dz, rd_data, hi, lo);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: drives an iterative DIVU divider and holds HI/LO; DIV_ZERO_CHECK_EN short-circuits zero divisors
module muldiv_sequencer #(
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  muldiv_sequencer_if.slave bus,
  output logic [5:0]        div_signal,
  output logic [31:0]       div_a,
  output logic [31:0]       div_b,
  output logic              div_reset,
  input  logic [63:0]       div_out
);
  localparam logic [5:0] OP_DIVU = 6'd27;
  localparam logic [5:0] OP_MFHI = 6'd16;
  localparam logic [5:0] OP_MFLO = 6'd18;
  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, RUN, OUT, CAPT, FIN} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic          accept;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    accept  = (state_q == IDLE || state_q == FIN) && bus.start && bus.op == OP_DIVU;
    case (state_q)
      RUN: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == LAST ? OUT : RUN;
      end
      OUT:  state_d = CAPT;
      CAPT: begin
        state_d = FIN;
        hi_d    = div_out[31:0];
        lo_d    = div_out[63:32];
      end
      default: state_d = IDLE;
    endcase
    // FIN doubles as an accept slot so back-to-back divides lose no cycle
    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      a_d     = bus.rs_val;
      b_d     = bus.rt_val;
`ifdef DIV_ZERO_CHECK_EN
      if (bus.rt_val == '0) begin
        state_d = FIN;
        hi_d    = bus.rs_val;
        lo_d    = '1;
      end
`endif
    end
  end
  assign bus.busy    = state_q inside {RUN, OUT, CAPT};
  assign bus.done    = state_q == FIN;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.rd_data = bus.op == OP_MFHI ? hi_q : bus.op == OP_MFLO ? lo_q : '0;
  assign div_signal  = state_q == RUN ? 6'd27 : state_q == OUT ? 6'd63 : 6'd0;
  assign div_a       = a_q;
  assign div_b       = b_q;
  assign div_reset   = ~reset_n;
`ifdef DIV_ZERO_CHECK_EN
  // only the short-circuit path can reach FIN with a zero divisor latched
  assign bus.dz      = state_q == FIN && b_q == '0;
`else
  assign bus.dz      = 1'b0;
`endif
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed DIVU/MFHI/MFLO vectors against a scoreboard, with a stub divider
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [5:0]  div_signal;
  logic [31:0] div_a, div_b;
  logic        div_reset;
  logic [63:0] div_out;
  logic [5:0]  steps;
  int tests = 0, fails = 0, cyc = 0, done_cnt = 0, busy_run = 0;
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
    int          busy;
    int          acc;
  } exp_t;
  exp_t sb[$];
  muldiv_sequencer_if bus();
  muldiv_sequencer dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .div_signal(div_signal), .div_a(div_a), .div_b(div_b),
    .div_reset(div_reset), .div_out(div_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // stub divider: answers correctly only after exactly 32 step cycles
  always @(posedge clk or posedge div_reset)
    if (div_reset) begin
      steps   <= '0;
      div_out <= '0;
    end else if (div_signal == 6'd27) steps <= steps + 1'b1;
    else if (div_signal == 6'd63) begin
      steps   <= '0;
      div_out <= steps != 6'd32 ? 64'hBAD0_BAD0_BAD0_BAD0 :
                 div_b == 32'd0 ? {32'hFFFF_FFFF, div_a} : {div_a / div_b, div_a % div_b};
    end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic divu(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lo_e,
                      input logic [31:0] hi_e, input logic dz_e, input int lat_e, input int busy_e);
    exp_t e;
    bus.start  = 1'b1;
    bus.op     = 6'd27;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge clk);
    #1;
    e.lo = lo_e; e.hi = hi_e; e.dz = dz_e; e.lat = lat_e; e.busy = busy_e; e.acc = cyc;
    sb.push_back(e);
    bus.start = 1'b0;
    bus.op    = 6'd0;
  endtask
  task automatic wait_done(input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < max);
    if (!bus.done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done within %0d cycles", max);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) busy_run = 0;
      else begin
        if (bus.busy) busy_run++;
        if (bus.done) begin
          done_cnt++;
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1 expected no pending op");
          end else begin
            e = sb.pop_front();
            chk("lo", 64'(bus.lo), 64'(e.lo));
            chk("hi", 64'(bus.hi), 64'(e.hi));
            chk("dz", 64'(bus.dz), 64'(e.dz));
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            chk("busy_cycles", 64'(busy_run), 64'(e.busy));
          end
          busy_run = 0;
        end
      end
    end
  end
  initial begin
    int d0;
    bus.start = 1'b0; bus.op = 6'd0; bus.rs_val = '0; bus.rt_val = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_div_signal", 64'(div_signal), 64'd0);
    chk("rst_div_a", 64'(div_a), 64'd0);
    chk("rst_div_reset", 64'(div_reset), 64'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    divu(100, 7, 14, 2, 1'b0, 34, 34);
    wait_done(60);
    bus.op = 6'd18;
    #1 chk("rd_mflo", 64'(bus.rd_data), 64'd14);
    bus.op = 6'd16;
    #1 chk("rd_mfhi", 64'(bus.rd_data), 64'd2);
    bus.op = 6'd5;
    #1 chk("rd_other", 64'(bus.rd_data), 64'd0);
    bus.op = 6'd16;
    @(negedge clk);
    chk("mfhi_keeps_hi", 64'(bus.hi), 64'd2);
    bus.op = 6'd0;
    divu(32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 1'b0, 34, 34);
    wait_done(60);
    divu(9, 3, 3, 0, 1'b0, 34, 34);
    wait_done(60);
    @(negedge clk);
`ifdef DIV_ZERO_CHECK_EN
    divu(50, 0, 32'hFFFF_FFFF, 50, 1'b1, 0, 0);
`else
    divu(50, 0, 32'hFFFF_FFFF, 50, 1'b0, 34, 34);
`endif
    wait_done(60);
    @(negedge clk);
    divu(100, 7, 14, 2, 1'b0, 34, 34);
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.op = 6'd27; bus.rs_val = 8; bus.rt_val = 2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("div_a_hold", 64'(div_a), 64'd100);
    end
    bus.start = 1'b0; bus.op = 6'd0;
    wait_done(60);
    chk("div_a_at_done", 64'(div_a), 64'd100);
    chk("div_b_at_done", 64'(div_b), 64'd7);
    @(negedge clk);
    divu(100, 7, 14, 2, 1'b0, 34, 34);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_div_signal", 64'(div_signal), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_lo", 64'(bus.lo), 64'd0);
    chk("abort_div_a", 64'(div_a), 64'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    d0 = done_cnt;
    repeat (45) @(negedge clk);
    chk("no_done_after_abort", 64'(done_cnt), 64'(d0));
    chk("idle_after_abort", 64'(bus.busy), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
